reg_file_wr_arb: RTL and testbench
==================================

REG_FILE_WR_ARB -- requirements
Module: reg_file_wr_arb

Interface
REQ-001 SHALL: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL: rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL: hold  input  1  pipeline stall; blocks all grants while 1.
REQ-004 SHALL: req0_valid  input  1  requester 0 (ALU writeback) has a write pending.
REQ-005 SHALL: req0_reg  input  5 (rf_addr_t)  requester 0 destination register.
REQ-006 SHALL: req0_data  input  32 (word_t)  requester 0 write data.
REQ-007 SHALL: req0_ready  output  1  requester 0 granted this cycle (combinational).
REQ-008 SHALL: req1_valid / req1_reg / req1_data / req1_ready  same as requester 0, for requester 1 (load writeback).
REQ-009 SHALL: wr_en  output  1  registered register-file write enable.
REQ-010 SHALL: wr_reg  output  5 (rf_addr_t)  registered register-file write address.
REQ-011 SHALL: wr_data  output  32 (word_t)  registered register-file write data.
REQ-012 SHALL: prio  output  1  current conflict-priority requester index.

Function
REQ-013 SHALL: transfer on requester k occurs when reqk_valid && reqk_ready.
REQ-014 SHALL: hold=1 -> req0_ready=req1_ready=0; no transfer; prio unchanged.
REQ-015 SHALL: hold=0, exactly one valid -> that requester's ready=1, other ready=0.
REQ-016 SHALL: hold=0, both valid (conflict) -> requester prio gets ready=1, other ready=0.
REQ-017 SHALL: after a conflict cycle, prio flips to the losing requester; non-conflict cycles leave prio unchanged.
REQ-018 SHALL: at most one ready asserted per cycle; ready never asserted without matching valid.
REQ-019 SHALL: a transfer in cycle N drives wr_en=1, wr_reg, and wr_data with the granted request's values in cycle N+1 (latency 1), for exactly one cycle.
REQ-020 SHALL: a transfer with reqk_reg=0 is accepted (ready=1) but produces wr_en=0 in cycle N+1; wr_reg/wr_data still update.
REQ-021 SHALL: with no transfer in cycle N, wr_en=0 in N+1; wr_reg/wr_data hold previous values.
REQ-022 SHALL: back-to-back transfers sustain one register-file write per cycle with no bubble.
REQ-023 SHALL: a losing requester holds valid/reg/data stable until granted; the arbiter does not buffer ungranted requests.

Reset
REQ-024 SHALL: rst=1 forces wr_en=0, wr_reg=0, wr_data=0, prio=0, and all statistics counters to 0, immediately and independent of clk.
REQ-025 SHALL: while rst=1, req0_ready=req1_ready=0.
REQ-026 SHALL: a request accepted in the cycle rst asserts is discarded; no write reaches the register file.
REQ-027 SHALL: first rising edge after rst deasserts arbitrates normally, with prio=0.

Configuration
REQ-028 SHALL: macro REG_FILE_WR_ARB_STATS_EN defined -> add outputs grant0_cnt, grant1_cnt, conflict_cnt (16 bits each).
REQ-029 SHALL: grantk_cnt increments on each transfer of requester k, including x0 writes; conflict_cnt increments on each conflict cycle with hold=0; all three saturate at 16'hFFFF.
REQ-030 SHALL: macro undefined -> counter ports and logic absent; all other behaviour identical.

Verification
REQ-031 SHALL: reset release, req0 valid reg=5 data=32'hDEADBEEF, req1 idle -> req0_ready=1; next cycle wr_en=1, wr_reg=5, wr_data=32'hDEADBEEF.
REQ-032 SHALL: both valid for 4 cycles (req0 reg=1/2, req1 reg=3/4, each advancing after grant) -> grants alternate 0,1,0,1; wr_reg sequence 1,3,2,4; prio ends at 0.
REQ-033 SHALL: req1 valid reg=0 data=32'h12345678 -> req1_ready=1; next cycle wr_en=0.
REQ-034 SHALL: hold=1 with both valid for 3 cycles -> both ready=0, wr_en=0, prio unchanged; on hold=0, prio requester granted first.
REQ-035 SHALL: rst asserted mid-stream during a cycle with req0 transfer reg=7 -> wr_en=0, prio=0, counters=0 immediately; no write to reg 7 appears.
REQ-036 SHALL: with REG_FILE_WR_ARB_STATS_EN, 70000 consecutive req0-only transfers -> grant0_cnt=16'hFFFF, grant1_cnt=0, conflict_cnt=0.

Source files
------------

// File: rtl/reg_file_wr_arb_if.sv
// Write-arbiter bus: two writeback requesters, the stall input, the register-file write port and the priority flag.
// Latency: n/a (wiring only). The ready signals are combinational and are driven back by the arbiter.
// Backpressure: a requester holds valid, reg and data stable until it sees ready in the same cycle.
interface reg_file_wr_arb_if;
    typedef logic [4:0]  rf_addr_t;
    typedef logic [31:0] word_t;

    logic     hold;

    logic     req0_valid;
    rf_addr_t req0_reg;
    word_t    req0_data;
    logic     req0_ready;

    logic     req1_valid;
    rf_addr_t req1_reg;
    word_t    req1_data;
    logic     req1_ready;

    logic     wr_en;
    rf_addr_t wr_reg;
    word_t    wr_data;
    logic     prio;

    // Requester and pipeline side.
    modport master (
        output hold,
        output req0_valid, req0_reg, req0_data,
        output req1_valid, req1_reg, req1_data,
        input  req0_ready, req1_ready,
        input  wr_en, wr_reg, wr_data, prio
    );

    // Arbiter side.
    modport slave (
        input  hold,
        input  req0_valid, req0_reg, req0_data,
        input  req1_valid, req1_reg, req1_data,
        output req0_ready, req1_ready,
        output wr_en, wr_reg, wr_data, prio
    );
endinterface

// File: rtl/reg_file_wr_arb.sv
// Two-requester register-file write arbiter. On a conflict, priority passes to the loser. Writes to x0 are accepted and then suppressed.
// Latency: 1 cycle from grant to the registered write port. Ready is combinational. Both readies are low while hold or rst is high.
// Optional macro REG_FILE_WR_ARB_STATS_EN adds saturating 16-bit counters: grant0_cnt, grant1_cnt and conflict_cnt.
module reg_file_wr_arb (
    input  logic                clk,
    input  logic                rst,
    reg_file_wr_arb_if.slave    bus
`ifdef REG_FILE_WR_ARB_STATS_EN
    ,
    output logic [15:0]         grant0_cnt,
    output logic [15:0]         grant1_cnt,
    output logic [15:0]         conflict_cnt
`endif
);

    typedef enum logic {
        PRIO_REQ0 = 1'b0,
        PRIO_REQ1 = 1'b1
    } prio_state_t;

    prio_state_t prio_q;
    prio_state_t prio_d;
    logic        grant0;
    logic        grant1;
    logic        conflict;

    // Priority state register. Reset returns priority to requester 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_q <= PRIO_REQ0;
        end else begin
            prio_q <= prio_d;
        end
    end

    // Grant decode and next priority. Only an unstalled conflict moves priority, and it moves to the loser.
    always_comb begin
        grant0   = 1'b0;
        grant1   = 1'b0;
        conflict = 1'b0;
        prio_d   = prio_q;
        if (!rst && !bus.hold) begin
            conflict = bus.req0_valid && bus.req1_valid;
            if (conflict) begin
                if (prio_q == PRIO_REQ0) begin
                    grant0 = 1'b1;
                    prio_d = PRIO_REQ1;
                end else begin
                    grant1 = 1'b1;
                    prio_d = PRIO_REQ0;
                end
            end else begin
                grant0 = bus.req0_valid;
                grant1 = bus.req1_valid;
            end
        end
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.prio       = prio_q;

    // Registered write port. A granted x0 write updates reg and data but keeps wr_en low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.wr_en   <= 1'b0;
            bus.wr_reg  <= 5'd0;
            bus.wr_data <= 32'd0;
        end else if (grant0) begin
            bus.wr_en   <= (bus.req0_reg != 5'd0);
            bus.wr_reg  <= bus.req0_reg;
            bus.wr_data <= bus.req0_data;
        end else if (grant1) begin
            bus.wr_en   <= (bus.req1_reg != 5'd0);
            bus.wr_reg  <= bus.req1_reg;
            bus.wr_data <= bus.req1_data;
        end else begin
            bus.wr_en   <= 1'b0;
        end
    end

`ifdef REG_FILE_WR_ARB_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Saturating statistics. A conflict counts only when it is unstalled, which is when it produces a grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant0_cnt   <= 16'd0;
            grant1_cnt   <= 16'd0;
            conflict_cnt <= 16'd0;
        end else begin
            if (grant0) begin
                grant0_cnt <= sat_inc(grant0_cnt);
            end
            if (grant1) begin
                grant1_cnt <= sat_inc(grant1_cnt);
            end
            if (conflict) begin
                conflict_cnt <= sat_inc(conflict_cnt);
            end
        end
    end
`endif

endmodule

// File: tb/tb_reg_file_wr_arb.sv
// Self-checking bench for reg_file_wr_arb: directed scenarios with literal expectations, followed by random traffic against a behavioural model.
// The model is evaluated on every falling edge. Inputs change 1 time unit after each rising edge.
// Build with REG_FILE_WR_ARB_STATS_EN defined to also exercise the counters, including the saturation run.
module tb_reg_file_wr_arb;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    reg_file_wr_arb_if bus ();

`ifdef REG_FILE_WR_ARB_STATS_EN
    logic [15:0] grant0_cnt;
    logic [15:0] grant1_cnt;
    logic [15:0] conflict_cnt;
`endif

    reg_file_wr_arb dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus)
`ifdef REG_FILE_WR_ARB_STATS_EN
        ,
        .grant0_cnt   (grant0_cnt),
        .grant1_cnt   (grant1_cnt),
        .conflict_cnt (conflict_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: the priority owner, the last write and the grant counts.
    int          m_prio;
    logic        m_wr_en;
    logic [4:0]  m_wr_reg;
    logic [31:0] m_wr_data;
    int          m_g0_cnt;
    int          m_g1_cnt;
    int          m_cf_cnt;
    bit          mg0;
    bit          mg1;
    bit          m_cf;

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_ready0", bus.req0_ready, 0);
            chk("rst_ready1", bus.req1_ready, 0);
            chk("rst_wr_en", bus.wr_en, 0);
            chk("rst_wr_reg", bus.wr_reg, 0);
            chk("rst_wr_data", bus.wr_data, 0);
            chk("rst_prio", bus.prio, 0);
            m_prio = 0; m_wr_en = 0; m_wr_reg = 0; m_wr_data = 0;
            m_g0_cnt = 0; m_g1_cnt = 0; m_cf_cnt = 0;
            mg0 = 0; mg1 = 0;
        end else begin
            mg0 = 0; mg1 = 0; m_cf = 0;
            if (!bus.hold) begin
                if (bus.req0_valid && bus.req1_valid) begin
                    m_cf = 1;
                    if (m_prio == 0) mg0 = 1; else mg1 = 1;
                end else begin
                    mg0 = bus.req0_valid;
                    mg1 = bus.req1_valid;
                end
            end
            chk("m_ready0", bus.req0_ready, mg0);
            chk("m_ready1", bus.req1_ready, mg1);
            chk("m_wr_en", bus.wr_en, m_wr_en);
            chk("m_wr_reg", bus.wr_reg, m_wr_reg);
            chk("m_wr_data", bus.wr_data, m_wr_data);
            chk("m_prio", bus.prio, m_prio);
`ifdef REG_FILE_WR_ARB_STATS_EN
            chk("m_grant0_cnt", grant0_cnt, m_g0_cnt);
            chk("m_grant1_cnt", grant1_cnt, m_g1_cnt);
            chk("m_conflict_cnt", conflict_cnt, m_cf_cnt);
`endif
            // Advance the model to the state that follows the coming rising edge.
            if (mg0) begin
                m_wr_en = (bus.req0_reg != 0); m_wr_reg = bus.req0_reg; m_wr_data = bus.req0_data;
            end else if (mg1) begin
                m_wr_en = (bus.req1_reg != 0); m_wr_reg = bus.req1_reg; m_wr_data = bus.req1_data;
            end else begin
                m_wr_en = 0;
            end
            if (m_cf) m_prio = 1 - m_prio;
            if (mg0 && m_g0_cnt < 65535) m_g0_cnt++;
            if (mg1 && m_g1_cnt < 65535) m_g1_cnt++;
            if (m_cf && m_cf_cnt < 65535) m_cf_cnt++;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic h, input logic v0, input logic [4:0] r0, input logic [31:0] d0,
                         input logic v1, input logic [4:0] r1, input logic [31:0] d1);
        bus.hold = h;
        bus.req0_valid = v0; bus.req0_reg = r0; bus.req0_data = d0;
        bus.req1_valid = v1; bus.req1_reg = r1; bus.req1_data = d1;
    endtask

    bit          p0;
    bit          p1;
    logic [4:0]  pr0;
    logic [4:0]  pr1;
    logic [31:0] pd0;
    logic [31:0] pd1;

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        drive(0, 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'd0);
        @(posedge clk); @(posedge clk); #2;
        chk("reset_ready0", bus.req0_ready, 0);
        chk("reset_wr_en", bus.wr_en, 0);
        chk("reset_wr_data", bus.wr_data, 0);
        chk("reset_prio", bus.prio, 0);

        // Reset release with a single requester.
        cyc(); rst = 1'b0; #1;
        chk("single_ready0", bus.req0_ready, 1);
        chk("single_ready1", bus.req1_ready, 0);

        // Alternating conflicts.
        cyc(); drive(0, 1, 5'd1, 32'hA1, 1, 5'd3, 32'hB3); #1;
        chk("single_wr_en", bus.wr_en, 1);
        chk("single_wr_reg", bus.wr_reg, 5);
        chk("single_wr_data", bus.wr_data, 32'hDEADBEEF);
        chk("alt1_ready0", bus.req0_ready, 1);
        cyc(); drive(0, 1, 5'd2, 32'hA2, 1, 5'd3, 32'hB3); #1;
        chk("alt2_wr_reg", bus.wr_reg, 1);
        chk("alt2_prio", bus.prio, 1);
        chk("alt2_ready1", bus.req1_ready, 1);
        cyc(); drive(0, 1, 5'd2, 32'hA2, 1, 5'd4, 32'hB4); #1;
        chk("alt3_wr_reg", bus.wr_reg, 3);
        chk("alt3_ready0", bus.req0_ready, 1);
        cyc(); drive(0, 1, 5'd9, 32'hA9, 1, 5'd4, 32'hB4); #1;
        chk("alt4_wr_reg", bus.wr_reg, 2);
        chk("alt4_ready1", bus.req1_ready, 1);
        cyc(); drive(0, 1, 5'd9, 32'hA9, 0, 5'd0, 32'd0); #1;
        chk("alt_end_wr_reg", bus.wr_reg, 4);
        chk("alt_end_prio", bus.prio, 0);

        // x0 write.
        cyc(); drive(0, 0, 5'd0, 32'd0, 1, 5'd0, 32'h12345678); #1;
        chk("x0_ready1", bus.req1_ready, 1);
        cyc(); drive(0, 1, 5'd10, 32'hC10, 1, 5'd11, 32'hC11); #1;
        chk("x0_wr_en", bus.wr_en, 0);
        chk("x0_wr_data", bus.wr_data, 32'h12345678);

        // Hold with both requesters valid.
        cyc(); drive(1, 1, 5'd12, 32'hC12, 1, 5'd11, 32'hC11); #1;
        chk("hold_ready0", bus.req0_ready, 0);
        chk("hold_ready1", bus.req1_ready, 0);
        chk("hold_prio", bus.prio, 1);
        repeat (2) begin
            cyc(); #1;
            chk("hold_wr_en", bus.wr_en, 0);
            chk("hold_ready_any", {31'd0, bus.req0_ready | bus.req1_ready}, 0);
            chk("hold_prio_kept", bus.prio, 1);
        end
        cyc(); bus.hold = 1'b0; #1;
        chk("unhold_ready1", bus.req1_ready, 1);
        chk("unhold_ready0", bus.req0_ready, 0);
        cyc(); drive(0, 1, 5'd12, 32'hC12, 0, 5'd0, 32'd0); #1;
        chk("unhold_wr_reg", bus.wr_reg, 11);

        // Reset asserted in the middle of a cycle that carries a transfer.
        cyc(); drive(0, 1, 5'd13, 32'hC13, 1, 5'd14, 32'hC14); #1;
        cyc(); drive(0, 0, 5'd0, 32'd0, 1, 5'd14, 32'hC14); #1;
        chk("pre_rst_prio", bus.prio, 1);
        cyc(); drive(0, 1, 5'd7, 32'h77, 0, 5'd0, 32'd0); #1;
        chk("pre_rst_ready0", bus.req0_ready, 1);
        chk("pre_rst_wr_en", bus.wr_en, 1);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_wr_en", bus.wr_en, 0);
        chk("async_rst_wr_reg", bus.wr_reg, 0);
        chk("async_rst_prio", bus.prio, 0);
        chk("async_rst_ready0", bus.req0_ready, 0);
`ifdef REG_FILE_WR_ARB_STATS_EN
        chk("async_rst_g0cnt", grant0_cnt, 0);
        chk("async_rst_g1cnt", grant1_cnt, 0);
        chk("async_rst_cfcnt", conflict_cnt, 0);
`endif
        cyc(); drive(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0); rst = 1'b0; #1;
        chk("no_reg7_wr_en", bus.wr_en, 0);
        chk("no_reg7_wr_reg", bus.wr_reg, 0);

        // Random traffic. Losing requesters keep their request stable until granted.
        p0 = 0; p1 = 0; pr0 = 0; pr1 = 0; pd0 = 0; pd1 = 0;
        for (int i = 0; i < 3000; i++) begin
            cyc();
            if (mg0) p0 = 0;
            if (mg1) p1 = 0;
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 199) == 0) rst = 1'b1;
            if (!p0 && $urandom_range(0, 99) < 55) begin
                p0 = 1; pr0 = 5'($urandom_range(0, 31)); pd0 = $urandom;
            end
            if (!p1 && $urandom_range(0, 99) < 55) begin
                p1 = 1; pr1 = 5'($urandom_range(0, 31)); pd1 = $urandom;
            end
            drive($urandom_range(0, 99) < 12, p0, pr0, pd0, p1, pr1, pd1);
        end

`ifdef REG_FILE_WR_ARB_STATS_EN
        // Counter saturation with only requester 0 active.
        cyc(); drive(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0); rst = 1'b1;
        cyc(); rst = 1'b0;
        for (int i = 0; i < 70000; i++) begin
            drive(0, 1, 5'($urandom_range(0, 31)), $urandom, 0, 5'd0, 32'd0);
            cyc();
        end
        drive(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0); #1;
        chk("sat_grant0_cnt", grant0_cnt, 16'hFFFF);
        chk("sat_grant1_cnt", grant1_cnt, 0);
        chk("sat_conflict_cnt", conflict_cnt, 0);
`endif

        cyc(); cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
